writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n_i  input  1  synchronous reset, active-low.
REQ-004 m_valid_i  input  1  memory stage offers a retiring instruction.
REQ-005 m_ready_o  output  1  block accepts the offer this cycle.
REQ-006 m_stat_i  input  3  status code: AOK=1, HLT=2, ADR=3, INS=4.
REQ-007 m_dstE_i / m_dstM_i  input  4 each  destination register IDs; 4'hF = none.
REQ-008 m_valE_i / m_valM_i  input  64 each  ALU result and memory load result.
REQ-009 dstA_o / dstB_o  output  4 each  register file write port IDs, carrying E and M respectively.
REQ-010 dstA_data_o / dstB_data_o  output  64 each  register file write data.
REQ-011 stat_o  output  3  architectural status.
REQ-012 halt_o  output  1  processor stopped.
REQ-013 retired_o  output  32  count of retired AOK instructions.
REQ-014 fwd_dstE_o / fwd_dstM_o / fwd_valE_o / fwd_valM_o  output  4/4/64/64  W-stage bypass values.

Function
REQ-015 Handshake: transfer occurs when m_valid_i && m_ready_o; m_ready_o SHALL be 1 iff the FSM is in RUN.
REQ-016 On transfer, inputs SHALL be captured into a one-entry W register with w_valid=1; with no transfer, w_valid SHALL be 0 on the next cycle (bubble).
REQ-017 Latency: an instruction accepted at edge N SHALL drive the write ports throughout cycle N+1, so the register file updates at edge N+1.
REQ-018 When w_valid=1 and W.stat=AOK, outputs SHALL be dstA_o=W.dstE, dstA_data_o=W.valE, dstB_o=W.dstM, and dstB_data_o=W.valM; otherwise both IDs SHALL be 4'hF and data SHALL be 0.
REQ-019 If W.dstE==W.dstM!=4'hF, dstA_o SHALL be forced to 4'hF so that the M write wins.
REQ-020 FSM states SHALL be RUN, HALTED, and FAULT; RUN transitions to HALTED when W is valid with stat HLT, and to FAULT when W is valid with stat ADR or INS; HALTED and FAULT are left only by reset.
REQ-021 The non-AOK instruction that causes a transition SHALL perform no register write.
REQ-022 stat_o SHALL be AOK in RUN, HLT in HALTED, and the latched W.stat in FAULT; halt_o=1 SHALL hold in HALTED and FAULT.
REQ-023 retired_o SHALL increment by 1 per valid AOK instruction in W, and SHALL wrap from 32'hFFFFFFFF to 0.
REQ-024 An invalid m_stat_i value (0, 5-7) SHALL be treated as INS.
REQ-025 m_valid_i asserted in HALTED or FAULT SHALL be ignored: no capture and no count.

Reset
REQ-026 While rst_n_i=0 at a clock edge, the block SHALL clear w_valid and W, set the FSM to RUN, and set retired_o=0.
REQ-027 After reset, dstA_o=dstB_o=4'hF, data=0, stat_o=AOK, halt_o=0, and m_ready_o=1.
REQ-028 A reset asserted while W holds a valid instruction SHALL discard that instruction, so no write occurs in the following cycle.

Configuration
REQ-029 Macro WB_FWD_EN: when defined, the fwd_* outputs SHALL present W.dstE/valE/dstM/valM under the same gating as REQ-018/REQ-019.
REQ-030 When WB_FWD_EN is undefined, fwd_dstE_o=fwd_dstM_o=4'hF and fwd_val*_o=0 constantly; the ports SHALL remain present and no bypass logic SHALL be synthesized.

Structure
REQ-031 The shared package dawn_pkg SHALL hold the STAT_AOK/HLT/ADR/INS codes, REG_NONE=4'hF, and the WB FSM state encoding.
REQ-032 The block SHALL be flat, with no sub-module; the W register, FSM, and counter SHALL be local to writeback_unit.

Verification
REQ-033 Accept AOK instruction {dstE=2, valE=64'h10, dstM=F} at edge 1 -> cycle 2: dstA_o=2 and dstA_data_o=64'h10, dstB_o=F, retired_o=1 after edge 2.
REQ-034 Accept {dstE=4, dstM=4, valE=8, valM=64'hAA} -> dstA_o=F, dstB_o=4, dstB_data_o=64'hAA.
REQ-035 Accept HLT with dstE=3 -> no write; next cycle stat_o=2, halt_o=1, m_ready_o=0; a further m_valid_i leaves retired_o unchanged.
REQ-036 Accept stat=6 -> FAULT with stat_o=4 (INS), halt_o=1; then rst_n_i=0 for one edge -> stat_o=1, halt_o=0, retired_o=0.
REQ-037 Preload the counter to 32'hFFFFFFFF via back-to-back AOK instructions (force), retire one more -> retired_o=0.
REQ-038 Run with WB_FWD_EN defined and undefined: with W {dstE=5, valE=7}, fwd_dstE_o=5 and fwd_valE_o=7 when defined; F and 0 when undefined.

Source files
------------

// File: rtl/dawn_pkg.sv
// ============================================================================
// dawn_pkg: shared status codes, register-ID sentinel and write-back FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package dawn_pkg;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] REG_NONE = 4'hF;

   typedef enum logic [1:0] {
      WB_RUN    = 2'd0,
      WB_HALTED = 2'd1,
      WB_FAULT  = 2'd2
   } wb_state_t;

   // Any status code outside the architectural set is an illegal instruction.
   function automatic logic [2:0] norm_stat(input logic [2:0] s);
      case (s)
         STAT_AOK, STAT_HLT, STAT_ADR, STAT_INS: norm_stat = s;
         default:                                norm_stat = STAT_INS;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// writeback_unit: W pipeline register, register-file write ports, halt FSM
// and retired-instruction counter. Optional bypass outputs under WB_FWD_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module writeback_unit
   import dawn_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        m_valid_i,
   output logic        m_ready_o,
   input  logic [2:0]  m_stat_i,
   input  logic [3:0]  m_dstE_i,
   input  logic [3:0]  m_dstM_i,
   input  logic [63:0] m_valE_i,
   input  logic [63:0] m_valM_i,
   output logic [3:0]  dstA_o,
   output logic [3:0]  dstB_o,
   output logic [63:0] dstA_data_o,
   output logic [63:0] dstB_data_o,
   output logic [2:0]  stat_o,
   output logic        halt_o,
   output logic [31:0] retired_o,
   output logic [3:0]  fwd_dstE_o,
   output logic [3:0]  fwd_dstM_o,
   output logic [63:0] fwd_valE_o,
   output logic [63:0] fwd_valM_o
);

   wb_state_t   r_state;
   wb_state_t   w_state_nxt;
   logic        w_latch_fault;

   logic        r_w_valid;
   logic [2:0]  r_w_stat;
   logic [3:0]  r_w_dste;
   logic [3:0]  r_w_dstm;
   logic [63:0] r_w_vale;
   logic [63:0] r_w_valm;
   logic [2:0]  r_fault_stat;
   logic [31:0] r_retired;

   logic        w_xfer;
   logic        w_wr_en;
   logic        w_collide;
   logic [3:0]  w_dsta;
   logic [3:0]  w_dstb;
   logic [63:0] w_dsta_data;
   logic [63:0] w_dstb_data;

   assign m_ready_o = (r_state == WB_RUN);
   assign w_xfer    = m_valid_i && m_ready_o;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_w_valid <= 1'b0;
         r_w_stat  <= STAT_AOK;
         r_w_dste  <= REG_NONE;
         r_w_dstm  <= REG_NONE;
         r_w_vale  <= '0;
         r_w_valm  <= '0;
      end else begin
         r_w_valid <= w_xfer;
         if (w_xfer) begin
            r_w_stat <= norm_stat(m_stat_i);
            r_w_dste <= m_dstE_i;
            r_w_dstm <= m_dstM_i;
            r_w_vale <= m_valE_i;
            r_w_valm <= m_valM_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state      <= WB_RUN;
         r_fault_stat <= STAT_AOK;
      end else begin
         r_state <= w_state_nxt;
         if (w_latch_fault) begin
            r_fault_stat <= r_w_stat;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_latch_fault = 1'b0;
      case (r_state)
         WB_RUN: begin
            if (r_w_valid) begin
               if (r_w_stat == STAT_HLT) begin
                  w_state_nxt = WB_HALTED;
               end else if ((r_w_stat == STAT_ADR) || (r_w_stat == STAT_INS)) begin
                  w_state_nxt   = WB_FAULT;
                  w_latch_fault = 1'b1;
               end
            end
         end
         default: w_state_nxt = r_state;
      endcase
   end

   always_comb begin
      stat_o = STAT_AOK;
      halt_o = 1'b0;
      case (r_state)
         WB_HALTED: begin
            stat_o = STAT_HLT;
            halt_o = 1'b1;
         end
         WB_FAULT: begin
            stat_o = r_fault_stat;
            halt_o = 1'b1;
         end
         default: begin
            stat_o = STAT_AOK;
            halt_o = 1'b0;
         end
      endcase
   end

   // The RUN term squashes anything that slipped into W behind a terminating
   // instruction during the single cycle before the FSM leaves RUN.
   assign w_wr_en   = r_w_valid && (r_w_stat == STAT_AOK) && (r_state == WB_RUN);
   assign w_collide = (r_w_dste == r_w_dstm) && (r_w_dste != REG_NONE);

   assign w_dsta      = (w_wr_en && !w_collide) ? r_w_dste : REG_NONE;
   assign w_dsta_data = w_wr_en ? r_w_vale : '0;
   assign w_dstb      = w_wr_en ? r_w_dstm : REG_NONE;
   assign w_dstb_data = w_wr_en ? r_w_valm : '0;

   assign dstA_o      = w_dsta;
   assign dstA_data_o = w_dsta_data;
   assign dstB_o      = w_dstb;
   assign dstB_data_o = w_dstb_data;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_retired <= '0;
      end else if (w_wr_en) begin
         r_retired <= r_retired + 32'd1;
      end
   end

   assign retired_o = r_retired;

`ifdef WB_FWD_EN
   assign fwd_dstE_o = w_dsta;
   assign fwd_valE_o = w_dsta_data;
   assign fwd_dstM_o = w_dstb;
   assign fwd_valM_o = w_dstb_data;
`else
   assign fwd_dstE_o = REG_NONE;
   assign fwd_valE_o = '0;
   assign fwd_dstM_o = REG_NONE;
   assign fwd_valM_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// tb_writeback_unit: randomized scoreboard bench for writeback_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_writeback_unit;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        m_valid_i = 1'b0;
   logic        m_ready_o;
   logic [2:0]  m_stat_i = 3'd1;
   logic [3:0]  m_dstE_i = 4'hF;
   logic [3:0]  m_dstM_i = 4'hF;
   logic [63:0] m_valE_i = '0;
   logic [63:0] m_valM_i = '0;
   logic [3:0]  dstA_o, dstB_o, fwd_dstE_o, fwd_dstM_o;
   logic [63:0] dstA_data_o, dstB_data_o, fwd_valE_o, fwd_valM_o;
   logic [2:0]  stat_o;
   logic        halt_o;
   logic [31:0] retired_o;

`ifdef WB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   writeback_unit dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .m_valid_i(m_valid_i), .m_ready_o(m_ready_o),
      .m_stat_i(m_stat_i), .m_dstE_i(m_dstE_i), .m_dstM_i(m_dstM_i),
      .m_valE_i(m_valE_i), .m_valM_i(m_valM_i),
      .dstA_o(dstA_o), .dstB_o(dstB_o), .dstA_data_o(dstA_data_o), .dstB_data_o(dstB_data_o),
      .stat_o(stat_o), .halt_o(halt_o), .retired_o(retired_o),
      .fwd_dstE_o(fwd_dstE_o), .fwd_dstM_o(fwd_dstM_o),
      .fwd_valE_o(fwd_valE_o), .fwd_valM_o(fwd_valM_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [3:0]  da;
      logic [63:0] va;
      logic [3:0]  db;
      logic [63:0] vb;
      logic [31:0] ret;
      bit          chk_ret;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_fail = 0;

   // Architectural model: stopped once a terminating instruction is accepted.
   bit          mdl_stopped = 1'b0;
   logic [2:0]  mdl_stat = 3'd1;
   logic [31:0] mdl_count = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a transfer seen mid-cycle is checked against the scoreboard one
   // cycle later; every other cycle must show an idle write port.
   bit   pend = 1'b0;
   exp_t mon_e;
   always @(negedge clk_i) begin
      if (!rst_n_i) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            if (q.size() == 0) begin
               chk("queue_underflow", 64'd1, 64'd0);
               mon_e = '{4'hF, 64'd0, 4'hF, 64'd0, 32'd0, 1'b0};
            end else begin
               mon_e = q.pop_front();
            end
         end else begin
            mon_e = '{4'hF, 64'd0, 4'hF, 64'd0, 32'd0, 1'b0};
         end
         chk("dstA", {60'd0, dstA_o}, {60'd0, mon_e.da});
         chk("dstA_data", dstA_data_o, mon_e.va);
         chk("dstB", {60'd0, dstB_o}, {60'd0, mon_e.db});
         chk("dstB_data", dstB_data_o, mon_e.vb);
         chk("fwd_dstE", {60'd0, fwd_dstE_o}, {60'd0, FWD ? mon_e.da : 4'hF});
         chk("fwd_valE", fwd_valE_o, FWD ? mon_e.va : 64'd0);
         chk("fwd_dstM", {60'd0, fwd_dstM_o}, {60'd0, FWD ? mon_e.db : 4'hF});
         chk("fwd_valM", fwd_valM_o, FWD ? mon_e.vb : 64'd0);
         if (mon_e.chk_ret) chk("retired_in_W", {32'd0, retired_o}, {32'd0, mon_e.ret});
         pend = m_valid_i && m_ready_o;
      end
   end

   task automatic send(input logic [2:0] st, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
      exp_t       e;
      logic [2:0] n;
      @(posedge clk_i); #1;
      m_valid_i = 1'b1; m_stat_i = st;
      m_dstE_i = de; m_valE_i = ve; m_dstM_i = dm; m_valM_i = vm;
      if (!mdl_stopped) begin
         n = (st >= 3'd1 && st <= 3'd4) ? st : 3'd4;
         e.ret = mdl_count;
         e.chk_ret = 1'b1;
         if (n == 3'd1) begin
            e.da = (de == dm && de != 4'hF) ? 4'hF : de;
            e.va = ve;
            e.db = dm;
            e.vb = vm;
            mdl_count = mdl_count + 32'd1;
         end else begin
            e.da = 4'hF; e.va = '0; e.db = 4'hF; e.vb = '0;
            mdl_stopped = 1'b1;
            mdl_stat = n;
         end
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i); #1;
         m_valid_i = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk_i); #1;
      rst_n_i = 1'b0; m_valid_i = 1'b0;
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      q.delete();
      mdl_stopped = 1'b0; mdl_stat = 3'd1; mdl_count = '0;
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_stat"}, {61'd0, stat_o}, {61'd0, mdl_stopped ? mdl_stat : 3'd1});
      chk({tag, "_halt"}, {63'd0, halt_o}, {63'd0, mdl_stopped});
      chk({tag, "_ready"}, {63'd0, m_ready_o}, {63'd0, !mdl_stopped});
      chk({tag, "_retired"}, {32'd0, retired_o}, {32'd0, mdl_count});
   endtask

   task automatic chk_drain(input string tag);
      chk({tag, "_queue_left"}, 64'(q.size()), 64'd0);
   endtask

   initial begin
      logic [2:0] bad [7];
      logic [3:0] de, dm;
      bad = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};

      do_reset();
      check_status("reset");

      // Single E write, then E/M collision where M wins.
      send(3'd1, 4'd2, 64'h10, 4'hF, 64'h0);
      idle(2);
      check_status("aok1");
      send(3'd1, 4'd4, 64'h8, 4'd4, 64'hAA);
      send(3'd1, 4'd5, 64'h7, 4'hF, 64'h0);
      idle(2);
      check_status("collide");

      // Halt, then offers while halted are ignored.
      send(3'd2, 4'd3, 64'h33, 4'hF, 64'h0);
      idle(2);
      check_status("halt");
      send(3'd1, 4'd1, 64'h1, 4'd2, 64'h2);
      send(3'd1, 4'd1, 64'h1, 4'd2, 64'h2);
      idle(2);
      check_status("halt_ignore");
      chk_drain("halt");

      // Invalid status code faults as INS; reset recovers.
      do_reset();
      send(3'd6, 4'd1, 64'h5, 4'd2, 64'h6);
      idle(2);
      check_status("fault_ins");
      do_reset();
      check_status("after_fault_reset");

      send(3'd3, 4'd1, 64'h5, 4'hF, 64'h0);
      idle(2);
      check_status("fault_adr");

      // Reset while W holds a valid instruction discards it.
      do_reset();
      send(3'd1, 4'd6, 64'h66, 4'd7, 64'h77);
      do_reset();
      idle(1);
      check_status("reset_discard");

      // Counter wrap from preloaded value.
      @(posedge clk_i); #1;
      force dut.r_retired = 32'hFFFF_FFFE;
      @(posedge clk_i); #1;
      release dut.r_retired;
      mdl_count = 32'hFFFF_FFFE;
      check_status("preload");
      send(3'd1, 4'd1, 64'h11, 4'hF, 64'h0);
      send(3'd1, 4'd2, 64'h22, 4'hF, 64'h0);
      idle(2);
      check_status("wrap");
      chk_drain("wrap");

      // Randomized episodes.
      for (int ep = 0; ep < 5; ep++) begin
         do_reset();
         for (int c = 0; c < 80; c++) begin
            de = 4'($urandom_range(0, 15));
            dm = ($urandom % 4 == 0) ? de : 4'($urandom_range(0, 15));
            if (!mdl_stopped && ($urandom % 4 == 0)) begin
               idle(1);
            end else if (!mdl_stopped && ($urandom % 40 == 0)) begin
               send(bad[$urandom % 7], de, {$urandom, $urandom}, dm, {$urandom, $urandom});
               idle(1);
            end else begin
               send(3'd1, de, {$urandom, $urandom}, dm, {$urandom, $urandom});
            end
         end
         idle(3);
         check_status("rand_end");
         chk_drain("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
